// File: rtl/ham_cmp_pkg.sv
// -----------------------------------------------------------------------------
// ham_cmp_pkg
// Shared definitions for the byte-serial popcount / compare unit.
//   - op_t    : operation encodings driven on the op port
//   - state_t : sequencer states
//   - NBYTES_DEF : default operand width in bytes
//   - pcnt_w() : width needed to hold a popcount of an 8*nbytes-bit word
// -----------------------------------------------------------------------------
package ham_cmp_pkg;

   localparam int NBYTES_DEF = 4;

   typedef enum logic [1:0] {
      OP_POPCNT = 2'b00,
      OP_SLT    = 2'b01,
      OP_SGT    = 2'b10,
      OP_SLTU   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int pcnt_w(input int nbytes);
      return $clog2(8 * nbytes + 1);
   endfunction

endpackage

// File: rtl/ham_cmp_seq_byte_slice.sv
// -----------------------------------------------------------------------------
// byte_slice
// Combinational 8-bit slice shared across all bytes of the operand.
// Ports:
//   a8   in  8  byte of operand A
//   b8   in  8  byte of operand B
//   bin  in  1  borrow in from the less significant byte
//   cnt4 out 4  popcount of a8 (0..8)
//   bout out 1  borrow out of a8 - b8 - bin (difference itself is not needed)
// -----------------------------------------------------------------------------
module byte_slice
   import ham_cmp_pkg::*;
(
   input  logic [7:0] a8,
   input  logic [7:0] b8,
   input  logic       bin,
   output logic [3:0] cnt4,
   output logic       bout
);

   // returns {carry, sum}
   function automatic logic [1:0] fadd1(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   logic [1:0] g0, g1, g2;   // 2-bit partial counts of bit triples
   logic [1:0] s_ones;       // {weight2, weight1} from the three sum bits
   logic [1:0] s_twos;       // {weight4, weight2} from the three carry bits
   logic       c_w4;
   logic       br;

   // Carry-save tree: three 3:2 compressors, then a second layer that
   // merges the weight-1 and weight-2 columns, then a final half-add.
   always_comb begin
      g0     = fadd1(a8[0], a8[1], a8[2]);
      g1     = fadd1(a8[3], a8[4], a8[5]);
      g2     = fadd1(a8[6], a8[7], 1'b0);
      s_ones = fadd1(g0[0], g1[0], g2[0]);
      s_twos = fadd1(g0[1], g1[1], g2[1]);
      c_w4   = s_ones[1] & s_twos[0];
      cnt4   = {s_twos[1] & c_w4, s_twos[1] ^ c_w4, s_ones[1] ^ s_twos[0], s_ones[0]};
   end

   // Ripple borrow chain, LSB first.
   always_comb begin
      br = bin;
      for (int i = 0; i < 8; i++) begin
         br = (~a8[i] & b8[i]) | (~(a8[i] ^ b8[i]) & br);
      end
      bout = br;
   end

endmodule

// File: rtl/ham_cmp_seq.sv
// -----------------------------------------------------------------------------
// ham_cmp_seq
// Multi-cycle functional unit computing POPCNT, SLT, SGT and SLTU by walking
// one shared byte_slice across the operand bytes, LSB first.
// Ports:
//   clk       in  1       clock, rising edge
//   rst       in  1       asynchronous active-high reset
//   in_valid  in  1       request valid
//   in_ready  out 1       unit idle and able to accept
//   op        in  2       00 POPCNT, 01 SLT, 10 SGT, 11 SLTU
//   a, b      in  DATA_W  operands (b ignored for POPCNT)
//   flush     in  1       synchronous abort while RUN or DONE
//   out_valid out 1       result valid
//   out_ready in  1       consumer accepts result
//   result    out DATA_W  zero-extended popcount or compare flag
// Build option: HAM_EARLY_EXIT_EN -- POPCNT stops after its highest nonzero
// byte instead of always walking NBYTES bytes.
// -----------------------------------------------------------------------------
module ham_cmp_seq
   import ham_cmp_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF,
   parameter int CNT_W  = 3
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            op,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   result
);

   localparam int DATA_W = 8 * NBYTES;
   localparam int ACC_W  = pcnt_w(NBYTES);

   state_t              state;
   op_t                 op_r;
   logic [DATA_W-1:0]   opr_a, opr_b;   // A' and B' (swapped for SGT)
   logic [CNT_W-1:0]    idx;
   logic [CNT_W-1:0]    last;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_nx;
   logic                borrow;
   logic [7:0]          a_byte, b_byte;
   logic [3:0]          cnt4;
   logic                bout;
   logic                flag;
   logic                accept;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && (state == IDLE);

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == i[CNT_W-1:0]) begin
            a_byte = opr_a[8*i +: 8];
            b_byte = opr_b[8*i +: 8];
         end
      end
   end

   byte_slice u_slice (
      .a8   (a_byte),
      .b8   (b_byte),
      .bin  (borrow),
      .cnt4 (cnt4),
      .bout (bout)
   );

   assign acc_nx = acc + {{(ACC_W-4){1'b0}}, cnt4};

   // Differing sign bits decide a signed compare outright; otherwise the
   // unsigned borrow is the answer, which stays correct under overflow.
   always_comb begin
      if (op_r == OP_SLTU)
         flag = bout;
      else if (opr_a[DATA_W-1] != opr_b[DATA_W-1])
         flag = opr_a[DATA_W-1];
      else
         flag = bout;
   end

`ifdef HAM_EARLY_EXIT_EN
   logic [CNT_W-1:0] hi_in, hi_r;

   always_comb begin
      hi_in = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (a[8*i +: 8] != 8'h00) hi_in = i[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) hi_r <= hi_in;
   end

   assign last = (op_r == OP_POPCNT) ? hi_r : CNT_W'(NBYTES - 1);
`else
   assign last = CNT_W'(NBYTES - 1);
`endif

   // Operand capture at accept
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r <= op_t'(op);
         if (op_t'(op) == OP_SGT) begin
            opr_a <= b;
            opr_b <= a;
         end else begin
            opr_a <= a;
            opr_b <= b;
         end
      end
   end

   // Sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         borrow    <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  idx    <= '0;
                  acc    <= '0;
                  borrow <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_nx;
                  borrow <= bout;
                  idx    <= idx + 1'b1;
                  if (idx == last) begin
                     result    <= (op_r == OP_POPCNT) ? {{(DATA_W-ACC_W){1'b0}}, acc_nx}
                                                      : {{(DATA_W-1){1'b0}}, flag};
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (flush || out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ham_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_ham_cmp_seq
// Scoreboard bench for ham_cmp_seq: expected result and latency are queued
// when a request is driven and compared when out_valid rises.
// -----------------------------------------------------------------------------
module tb_ham_cmp_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op_s;
   logic [31:0] a_s, b_s;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   ham_cmp_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op_s),
      .a         (a_s),
      .b         (b_s),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return 32'($countones(a));
         2'b01:   return {31'b0, $signed(a) < $signed(b)};
         2'b10:   return {31'b0, $signed(a) > $signed(b)};
         default: return {31'b0, a < b};
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [31:0] a);
`ifdef HAM_EARLY_EXIT_EN
      if (op == 2'b00) begin
         if (a[31:24] != 0) return 4;
         if (a[23:16] != 0) return 3;
         if (a[15:8]  != 0) return 2;
         return 1;
      end
`endif
      return 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
   endtask

   // Issue one request, hold the result for 'hold' cycles, then hand it off.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input bit idle_flush);
      int n;
      int exp_lat;
      logic [31:0] exp_r;
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(model_lat(op, a));
      wait_ready(tag);
      in_valid = 1'b1;
      op_s     = op;
      a_s      = a;
      b_s      = b;
      flush    = idle_flush;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      op_s     = 2'($urandom);
      a_s      = $urandom;
      b_s      = $urandom;
      n = 0;
      while (!out_valid && n < 20) begin
         chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
         tick();
         n++;
      end
      exp_lat = lat_q.pop_front();
      exp_r   = exp_q.pop_front();
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_res"}, result, exp_r);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_res"}, result, exp_r);
         chk({tag, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
         chk({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_post_vld"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_post_rdy"}, {31'b0, in_ready}, 32'd1);
      chk({tag, "_post_res"}, result, exp_r);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op_s      = 2'b00;
      a_s       = '0;
      b_s       = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_rdy", {31'b0, in_ready}, 32'd1);
      chk("rst_vld", {31'b0, out_valid}, 32'd0);
      chk("rst_res", result, 32'd0);
      rst = 1'b0;
      tick();

      // Directed cases
      run_op("pop_mix",   2'b00, 32'hF0F0_0F01, 32'h0,         0, 1'b0);
      run_op("slt_ovf",   2'b01, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
      run_op("sgt_ovf",   2'b10, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
      run_op("sltu_ovf",  2'b11, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
      run_op("slt_pn",    2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      run_op("sltu_eq",   2'b11, 32'h0000_0005, 32'h0000_0005, 0, 1'b0);
      run_op("sgt_small", 2'b10, 32'h0000_0006, 32'h0000_0005, 0, 1'b0);
      run_op("pop_full",  2'b00, 32'hFFFF_FFFF, 32'h0,         5, 1'b0);
      run_op("pop_zero",  2'b00, 32'h0000_0000, 32'h0,         0, 1'b0);
      run_op("pop_b1",    2'b00, 32'h0000_0300, 32'h0,         0, 1'b0);
      run_op("idle_fl",   2'b00, 32'h0000_0003, 32'h0,         0, 1'b1);

      // flush during RUN: no result ever appears
      wait_ready("flrun");
      in_valid = 1'b1; op_s = 2'b00; a_s = 32'h0000_00FF;
      tick();
      in_valid = 1'b0;
      chk("flrun_busy", {31'b0, in_ready}, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flrun_rdy", {31'b0, in_ready}, 32'd1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) n++;
      end
      chk("flrun_novld", 32'(n), 32'd0);
      run_op("pop_one", 2'b00, 32'h0000_0001, 32'h0, 0, 1'b0);

      // flush in DONE beats out_ready; result register keeps its value
      wait_ready("fldone");
      in_valid = 1'b1; op_s = 2'b11; a_s = 32'd5; b_s = 32'd6;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("fldone_vld", {31'b0, out_valid}, 32'd1);
      chk("fldone_res", result, 32'd1);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick();
      out_ready = 1'b0;
      flush     = 1'b0;
      chk("fldone_post_vld", {31'b0, out_valid}, 32'd0);
      chk("fldone_post_rdy", {31'b0, in_ready}, 32'd1);
      chk("fldone_post_res", result, 32'd1);

      // asynchronous reset mid-RUN
      wait_ready("rstrun");
      in_valid = 1'b1; op_s = 2'b00; a_s = 32'hFFFF_FFFF;
      tick();
      in_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rstrun_res", result, 32'd0);
      chk("rstrun_vld", {31'b0, out_valid}, 32'd0);
      chk("rstrun_rdy", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Randomised sweep
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra, rb;
         logic [1:0]  rop;
         ra  = $urandom;
         rb  = (i % 4 == 0) ? ra : $urandom;
         if (i % 6 == 1) rb = {~ra[31], ra[30:0]};
         rop = 2'(i % 4);
         run_op("rand", rop, ra, rb, i % 3, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
